mem_miss_arbiter: RTL and testbench
===================================

# mem_miss_arbiter

Arbitrates cache-line miss traffic from the data cache and the instruction cache onto the single main-memory port, and routes each memory response back to its requester. It sits directly downstream of the data cache's miss interface: it accepts single-cycle line fill and eviction pulses, holds them until memory accepts them, and returns one response pulse per request, with a bus-error flag where applicable. Only one memory transaction is outstanding at a time.

## Interface
- ADDR_W, 20, line address width (byte address >> 4)
- LINE_W, 128, cache line width in bits
- MEM_LINES, 4096, number of valid lines; a line address >= MEM_LINES is a bus error
- TIMEOUT_CYCLES, 64, watchdog limit (see Configuration)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- dc_req_valid  in  1  data-cache miss request pulse
- dc_req_addr  in  ADDR_W  line address
- dc_req_is_store  in  1  1 = eviction write, 0 = line fill
- dc_req_data  in  LINE_W  eviction data
- dc_rsp_valid  out  1  response pulse to data cache
- dc_rsp_data  out  LINE_W  fill data; 0 for stores and errors
- dc_rsp_bus_error  out  1  valid with dc_rsp_valid
- ic_req_valid  in  1  instruction-cache fill request pulse (read only)
- ic_req_addr  in  ADDR_W  line address
- ic_rsp_valid / ic_rsp_data / ic_rsp_bus_error  out  1 / LINE_W / 1  same semantics as the data-cache response
- mem_req_valid  out  1  memory request; held until accepted
- mem_req_ready  in  1  memory accepts when valid & ready
- mem_req_addr  out  ADDR_W
- mem_req_is_store  out  1
- mem_req_data  out  LINE_W
- mem_rsp_valid  in  1  single-cycle memory completion
- mem_rsp_data  in  LINE_W

## Operation
- Each requester has a one-entry pending slot (valid, addr, is_store, data).
  - A req pulse captures into an empty slot.
  - A pulse arriving while the slot is valid is ignored.
  - The instruction-cache slot always has is_store = 0.
- Arbitration runs only in IDLE with at least one slot valid.
  - One slot valid: grant it.
  - Both valid: round-robin. Grant the port not granted last.
  - After reset, "last" = icache, so the data cache wins the first tie.
- FSM states: IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE -> ISSUE on a grant. The granted slot's contents drive mem_req_*; mem_req_valid = 1.
- Bus error path: if the granted addr >= MEM_LINES, go IDLE -> RESPOND with error = 1. No memory request is issued.
- ISSUE: hold mem_req_* stable until mem_req_ready, then go to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, capture mem_rsp_data (forced to 0 for stores), then go to RESPOND.
- RESPOND: for one cycle, assert the granted port's rsp_valid with data and bus_error. Clear that slot, then go to IDLE.
- rsp_data is 0 whenever bus_error = 1.

## Timing
- Reset values: all rsp_valid = 0, all rsp_data = 0, all bus_error = 0, mem_req_valid = 0, mem_req_is_store = 0, mem_req_addr = 0, mem_req_data = 0. State = IDLE, both slots empty, last = icache.
- Reset mid-transaction aborts the transaction; no response is produced. Memory must be reset together with this block.
- Request pulse in cycle N: slot valid in N+1, mem_req_valid in N+2 at the earliest.
- mem_rsp_valid in cycle M: rsp_valid in M+1. All outputs are registered.
- Minimum round trip with mem_req_ready tied high and 1-cycle memory latency: 5 cycles from pulse to response.
- A new pulse from a port in the same cycle as its RESPOND is captured, because the slot clears that edge. It is served in the next arbitration.
- mem_rsp_valid outside WAIT_RSP is ignored.
- The other port's pulse during any state is captured and waits in its slot.
- The bus-error path takes 3 cycles from pulse to response.

## Configuration
- MEM_MISS_ARB_TIMEOUT_EN defined:
  - A counter runs in ISSUE and WAIT_RSP.
  - After TIMEOUT_CYCLES cycles without progress, go to RESPOND with bus_error = 1, and drop mem_req_valid.
  - A late mem_rsp_valid is then ignored.
- Not defined: no counter. The block waits indefinitely for memory.

## Test plan
- dc fill addr 0x00010, memory returns 0xA5…A5 after 3 cycles -> dc_rsp_valid pulse with data 0xA5…A5, bus_error 0, ic outputs idle.
- dc store addr 0x00020, data 0x1234…, mem_req_ready low for 4 cycles -> mem_req_* held stable for all 4 cycles; after completion, dc_rsp_valid with data 0.
- dc and ic pulse in the same cycle after reset -> dc served first, ic second. Repeat the tie -> ic served first.
- ic fill addr 0x01000 (>= MEM_LINES) -> no mem_req_valid, ic_rsp_valid 3 cycles later with bus_error 1, data 0.
- With MEM_MISS_ARB_TIMEOUT_EN, memory never responds -> dc_rsp_bus_error 1 after TIMEOUT_CYCLES. A subsequent ic request completes normally.
- Reset asserted in WAIT_RSP -> all outputs 0, no response pulse. The next dc request completes normally.

Source files
------------

// File: rtl/mem_miss_arbiter.sv
// Arbitrates data/instruction cache line misses onto one memory port, one transaction outstanding.
// Optional watchdog: define MEM_MISS_ARB_TIMEOUT_EN to abort stalled transactions with a bus error.
module mem_miss_arbiter #(
    parameter int ADDR_W         = 20,
    parameter int LINE_W         = 128,
    parameter int MEM_LINES      = 4096,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dc_req_valid,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_is_store,
    input  logic [LINE_W-1:0] dc_req_data,
    output logic              dc_rsp_valid,
    output logic [LINE_W-1:0] dc_rsp_data,
    output logic              dc_rsp_bus_error,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_rsp_valid,
    output logic [LINE_W-1:0] ic_rsp_data,
    output logic              ic_rsp_bus_error,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_is_store,
    output logic [LINE_W-1:0] mem_req_data,
    input  logic              mem_rsp_valid,
    input  logic [LINE_W-1:0] mem_rsp_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

    localparam logic PORT_DC = 1'b0;
    localparam logic PORT_IC = 1'b1;

    state_t state_reg, state_next;

    logic              dc_slot_valid_reg;
    logic [ADDR_W-1:0] dc_slot_addr_reg;
    logic              dc_slot_store_reg;
    logic [LINE_W-1:0] dc_slot_data_reg;
    logic              ic_slot_valid_reg;
    logic [ADDR_W-1:0] ic_slot_addr_reg;

    logic grant_reg;
    logic last_reg;

    logic              mem_req_valid_reg;
    logic [ADDR_W-1:0] mem_req_addr_reg;
    logic              mem_req_store_reg;
    logic [LINE_W-1:0] mem_req_data_reg;

    logic              dc_rsp_valid_reg, ic_rsp_valid_reg;
    logic [LINE_W-1:0] dc_rsp_data_reg, ic_rsp_data_reg;
    logic              dc_rsp_err_reg, ic_rsp_err_reg;

    logic              any_pending;
    logic              grant_pick;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_store;
    logic [LINE_W-1:0] pick_data;
    logic              pick_err;
    logic              rsp_port;
    logic              start_issue;
    logic              enter_rsp;
    logic              rsp_err;
    logic [LINE_W-1:0] rsp_data;
    logic              timeout_hit;
    logic              dc_clear, ic_clear;

    // On a tie, grant the port that did not win the previous arbitration.
    assign any_pending = dc_slot_valid_reg | ic_slot_valid_reg;
    assign grant_pick  = (dc_slot_valid_reg & ic_slot_valid_reg) ? ~last_reg : ic_slot_valid_reg;
    assign pick_addr   = (grant_pick == PORT_IC) ? ic_slot_addr_reg : dc_slot_addr_reg;
    assign pick_store  = (grant_pick == PORT_IC) ? 1'b0 : dc_slot_store_reg;
    assign pick_data   = (grant_pick == PORT_IC) ? '0 : dc_slot_data_reg;
    assign pick_err    = 32'(pick_addr) >= 32'(MEM_LINES);
    assign rsp_port    = (state_reg == IDLE) ? grant_pick : grant_reg;

`ifdef MEM_MISS_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer_reg;

    // Restarts whenever the FSM makes progress; counts only while waiting on memory.
    always_ff @(posedge clock) begin
        if (reset || state_next != state_reg) begin
            timer_reg <= '0;
        end else if (state_reg == ISSUE || state_reg == WAIT_RSP) begin
            timer_reg <= timer_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == ISSUE || state_reg == WAIT_RSP) &&
                         (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        start_issue = 1'b0;
        enter_rsp   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        case (state_reg)
            IDLE: begin
                if (any_pending) begin
                    if (pick_err) begin
                        state_next = RESPOND;
                        enter_rsp  = 1'b1;
                        rsp_err    = 1'b1;
                    end else begin
                        state_next  = ISSUE;
                        start_issue = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_next = WAIT_RSP;
                end else if (timeout_hit) begin
                    state_next = RESPOND;
                    enter_rsp  = 1'b1;
                    rsp_err    = 1'b1;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    state_next = RESPOND;
                    enter_rsp  = 1'b1;
                    rsp_data   = mem_req_store_reg ? '0 : mem_rsp_data;
                end else if (timeout_hit) begin
                    state_next = RESPOND;
                    enter_rsp  = 1'b1;
                    rsp_err    = 1'b1;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= IDLE;
            grant_reg         <= PORT_DC;
            last_reg          <= PORT_IC;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            mem_req_store_reg <= 1'b0;
            mem_req_data_reg  <= '0;
            dc_rsp_valid_reg  <= 1'b0;
            dc_rsp_data_reg   <= '0;
            dc_rsp_err_reg    <= 1'b0;
            ic_rsp_valid_reg  <= 1'b0;
            ic_rsp_data_reg   <= '0;
            ic_rsp_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_pending) begin
                grant_reg <= grant_pick;
                last_reg  <= grant_pick;
            end
            if (start_issue) begin
                mem_req_valid_reg <= 1'b1;
                mem_req_addr_reg  <= pick_addr;
                mem_req_store_reg <= pick_store;
                mem_req_data_reg  <= pick_data;
            end else if (state_reg == ISSUE && (mem_req_ready || timeout_hit)) begin
                mem_req_valid_reg <= 1'b0;
            end
            // Response registers are one-cycle pulses; data and error read as zero otherwise.
            dc_rsp_valid_reg <= enter_rsp && rsp_port == PORT_DC;
            dc_rsp_data_reg  <= (enter_rsp && rsp_port == PORT_DC) ? rsp_data : '0;
            dc_rsp_err_reg   <= enter_rsp && rsp_port == PORT_DC && rsp_err;
            ic_rsp_valid_reg <= enter_rsp && rsp_port == PORT_IC;
            ic_rsp_data_reg  <= (enter_rsp && rsp_port == PORT_IC) ? rsp_data : '0;
            ic_rsp_err_reg   <= enter_rsp && rsp_port == PORT_IC && rsp_err;
        end
    end

    // A slot frees at the end of its RESPOND cycle, so a pulse in that same cycle is kept.
    assign dc_clear = (state_reg == RESPOND) && (grant_reg == PORT_DC);
    assign ic_clear = (state_reg == RESPOND) && (grant_reg == PORT_IC);

    always_ff @(posedge clock) begin
        if (reset) begin
            dc_slot_valid_reg <= 1'b0;
            dc_slot_addr_reg  <= '0;
            dc_slot_store_reg <= 1'b0;
            dc_slot_data_reg  <= '0;
            ic_slot_valid_reg <= 1'b0;
            ic_slot_addr_reg  <= '0;
        end else begin
            if (dc_req_valid && (!dc_slot_valid_reg || dc_clear)) begin
                dc_slot_valid_reg <= 1'b1;
                dc_slot_addr_reg  <= dc_req_addr;
                dc_slot_store_reg <= dc_req_is_store;
                dc_slot_data_reg  <= dc_req_data;
            end else if (dc_clear) begin
                dc_slot_valid_reg <= 1'b0;
            end
            if (ic_req_valid && (!ic_slot_valid_reg || ic_clear)) begin
                ic_slot_valid_reg <= 1'b1;
                ic_slot_addr_reg  <= ic_req_addr;
            end else if (ic_clear) begin
                ic_slot_valid_reg <= 1'b0;
            end
        end
    end

    assign mem_req_valid    = mem_req_valid_reg;
    assign mem_req_addr     = mem_req_addr_reg;
    assign mem_req_is_store = mem_req_store_reg;
    assign mem_req_data     = mem_req_data_reg;
    assign dc_rsp_valid     = dc_rsp_valid_reg;
    assign dc_rsp_data      = dc_rsp_data_reg;
    assign dc_rsp_bus_error = dc_rsp_err_reg;
    assign ic_rsp_valid     = ic_rsp_valid_reg;
    assign ic_rsp_data      = ic_rsp_data_reg;
    assign ic_rsp_bus_error = ic_rsp_err_reg;

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed self-checking bench for mem_miss_arbiter; the bench itself plays the memory side.
module tb_mem_miss_arbiter;

    localparam int AW = 20;
    localparam int LW = 128;
    localparam int TIMEOUT = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          dc_req_valid, dc_req_is_store;
    logic [AW-1:0] dc_req_addr;
    logic [LW-1:0] dc_req_data;
    logic          dc_rsp_valid, dc_rsp_bus_error;
    logic [LW-1:0] dc_rsp_data;
    logic          ic_req_valid;
    logic [AW-1:0] ic_req_addr;
    logic          ic_rsp_valid, ic_rsp_bus_error;
    logic [LW-1:0] ic_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_is_store;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_data;
    logic          mem_rsp_valid;
    logic [LW-1:0] mem_rsp_data;

    int checks = 0;
    int errors = 0;

    mem_miss_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LINES(4096), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
        .dc_req_is_store(dc_req_is_store), .dc_req_data(dc_req_data),
        .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data), .dc_rsp_bus_error(dc_rsp_bus_error),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .ic_rsp_bus_error(ic_rsp_bus_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_is_store(mem_req_is_store), .mem_req_data(mem_req_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dc_req_valid = 0; dc_req_addr = '0; dc_req_is_store = 0; dc_req_data = '0;
        ic_req_valid = 0; ic_req_addr = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        reset = 1; clear_inputs();
        tick(); tick();
        reset = 0;
    endtask

    task automatic wait_mem_req(output int n);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            tick(); n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, ic_rsp_valid, ic_rsp_bus_error} !== 4'b0) begin
            errors++; $display("FAIL reset_rsp_flags: got %b expected 0000",
                {dc_rsp_valid, dc_rsp_bus_error, ic_rsp_valid, ic_rsp_bus_error});
        end
        checks++;
        if ({dc_rsp_data, ic_rsp_data} !== '0) begin
            errors++; $display("FAIL reset_rsp_data: got %h / %h expected 0", dc_rsp_data, ic_rsp_data);
        end
        checks++;
        if ({mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data} !== '0) begin
            errors++; $display("FAIL reset_mem_req: got v=%b s=%b a=%h d=%h expected all 0",
                mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_dc_fill();
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_addr = 20'h00010; dc_req_is_store = 0;
        tick(); dc_req_valid = 0;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL fill_early_req: got %b expected 0", mem_req_valid);
        end
        tick();
        checks++;
        if ({mem_req_valid, mem_req_is_store, mem_req_addr} !== {1'b1, 1'b0, 20'h00010}) begin
            errors++; $display("FAIL fill_issue: got v=%b s=%b a=%h expected v=1 s=0 a=00010",
                mem_req_valid, mem_req_is_store, mem_req_addr);
        end
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL fill_req_drop: got %b expected 0", mem_req_valid);
        end
        tick(); tick();
        mem_rsp_valid = 1; mem_rsp_data = {16{8'hA5}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data} !== {1'b1, 1'b0, {16{8'hA5}}}) begin
            errors++; $display("FAIL fill_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=a5..a5",
                dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data);
        end
        checks++;
        if ({ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data} !== '0) begin
            errors++; $display("FAIL fill_ic_idle: got v=%b e=%b d=%h expected 0",
                ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data);
        end
        tick();
        checks++;
        if ({dc_rsp_valid, dc_rsp_data} !== '0) begin
            errors++; $display("FAIL fill_rsp_pulse: got v=%b d=%h expected 0", dc_rsp_valid, dc_rsp_data);
        end
        $display("dc_fill: addr 00010 transaction checked");
    endtask

    task automatic test_dc_store();
        logic [LW-1:0] sdata;
        sdata = {4{32'h12345678}};
        mem_req_ready = 0;
        dc_req_valid = 1; dc_req_addr = 20'h00020; dc_req_is_store = 1; dc_req_data = sdata;
        tick(); dc_req_valid = 0; dc_req_is_store = 0; dc_req_data = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data} !== {1'b1, 1'b1, 20'h00020, sdata}) begin
                errors++; $display("FAIL store_hold[%0d]: got v=%b s=%b a=%h d=%h expected v=1 s=1 a=00020 d=%h",
                    i, mem_req_valid, mem_req_is_store, mem_req_addr, mem_req_data, sdata);
            end
            // A stray completion outside WAIT_RSP must be ignored.
            mem_rsp_valid = (i == 1); mem_rsp_data = '1;
            tick(); mem_rsp_valid = 0;
            checks++;
            if (dc_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL store_stray_rsp[%0d]: got %b expected 0", i, dc_rsp_valid);
            end
        end
        mem_req_ready = 1;
        tick();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL store_accept: got %b expected 0", mem_req_valid);
        end
        mem_rsp_valid = 1; mem_rsp_data = '1;
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data} !== {1'b1, 1'b0, {LW{1'b0}}}) begin
            errors++; $display("FAIL store_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0",
                dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data);
        end
        tick();
        $display("dc_store: addr 00020 held 4 cycles, response checked");
    endtask

    task automatic test_bus_error();
        mem_req_ready = 1;
        ic_req_valid = 1; ic_req_addr = 20'h01000;
        tick(); ic_req_valid = 0;
        checks++;
        if ({ic_rsp_valid, mem_req_valid} !== 2'b00) begin
            errors++; $display("FAIL berr_early: got rsp=%b req=%b expected 00", ic_rsp_valid, mem_req_valid);
        end
        tick();
        checks++;
        if ({ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data, mem_req_valid} !== {1'b1, 1'b1, {LW{1'b0}}, 1'b0}) begin
            errors++; $display("FAIL berr_rsp: got v=%b e=%b d=%h req=%b expected v=1 e=1 d=0 req=0",
                ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data, mem_req_valid);
        end
        tick();
        checks++;
        if ({ic_rsp_valid, ic_rsp_bus_error, mem_req_valid, dc_rsp_valid} !== 4'b0) begin
            errors++; $display("FAIL berr_after: got %b expected 0000",
                {ic_rsp_valid, ic_rsp_bus_error, mem_req_valid, dc_rsp_valid});
        end
        $display("bus_error: ic addr 01000 checked");
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_addr = 20'h00030;
        ic_req_valid = 1; ic_req_addr = 20'h00040;
        tick(); dc_req_valid = 0;
        ic_req_addr = 20'h00044;   // second ic pulse while its slot is full: dropped
        tick(); ic_req_valid = 0;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 20'h00030}) begin
            errors++; $display("FAIL rr_first_tie: got v=%b a=%h expected v=1 a=00030", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_data = {4{32'hD1D1D1D1}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({dc_rsp_valid, ic_rsp_valid, dc_rsp_data} !== {1'b1, 1'b0, {4{32'hD1D1D1D1}}}) begin
            errors++; $display("FAIL rr_dc_rsp: got dv=%b iv=%b d=%h expected dv=1 iv=0 d=d1..d1",
                dc_rsp_valid, ic_rsp_valid, dc_rsp_data);
        end
        // New dc pulse in its own RESPOND cycle -> second tie, which ic must win.
        dc_req_valid = 1; dc_req_addr = 20'h00034;
        tick(); dc_req_valid = 0;
        wait_mem_req(n);
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 20'h00040}) begin
            errors++; $display("FAIL rr_second_tie: got v=%b a=%h expected v=1 a=00040", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_data = {4{32'h1C1C1C1C}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({ic_rsp_valid, dc_rsp_valid, ic_rsp_data} !== {1'b1, 1'b0, {4{32'h1C1C1C1C}}}) begin
            errors++; $display("FAIL rr_ic_rsp: got iv=%b dv=%b d=%h expected iv=1 dv=0 d=1c..1c",
                ic_rsp_valid, dc_rsp_valid, ic_rsp_data);
        end
        wait_mem_req(n);
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 20'h00034}) begin
            errors++; $display("FAIL rr_dc_again: got v=%b a=%h expected v=1 a=00034", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_data = {4{32'hD2D2D2D2}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({dc_rsp_valid, dc_rsp_data} !== {1'b1, {4{32'hD2D2D2D2}}}) begin
            errors++; $display("FAIL rr_dc_again_rsp: got v=%b d=%h expected v=1 d=d2..d2", dc_rsp_valid, dc_rsp_data);
        end
        tick();
        $display("round_robin: dc, ic, dc order checked");
    endtask

`ifdef MEM_MISS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_addr = 20'h00050;
        tick(); dc_req_valid = 0;
        wait_mem_req(n);
        tick();
        n = 0;
        while (!dc_rsp_valid && n < 200) begin
            tick(); n++;
        end
        checks++;
        if (n !== TIMEOUT) begin
            errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT);
        end
        checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data} !== {1'b1, 1'b1, {LW{1'b0}}}) begin
            errors++; $display("FAIL timeout_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0",
                dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data);
        end
        mem_rsp_valid = 1; mem_rsp_data = '1;
        tick(); mem_rsp_valid = 0;
        tick();
        checks++;
        if (dc_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_late_rsp: got %b expected 0", dc_rsp_valid);
        end
        ic_req_valid = 1; ic_req_addr = 20'h00060;
        tick(); ic_req_valid = 0;
        wait_mem_req(n);
        tick();
        mem_rsp_valid = 1; mem_rsp_data = {4{32'h600D600D}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data} !== {1'b1, 1'b0, {4{32'h600D600D}}}) begin
            errors++; $display("FAIL timeout_next_ic: got v=%b e=%b d=%h expected v=1 e=0 d=600d..",
                ic_rsp_valid, ic_rsp_bus_error, ic_rsp_data);
        end
        tick();
        $display("timeout: dc abort after %0d cycles, ic follow-up checked", n);
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        int pulses;
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_addr = 20'h00070;
        tick(); dc_req_valid = 0;
        tick(); tick();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dc_rsp_valid || ic_rsp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_wait_no_rsp: got %0d pulses expected 0", pulses);
        end
        reset = 1;
        tick();
        checks++;
        if ({mem_req_valid, dc_rsp_valid, ic_rsp_valid, dc_rsp_data, mem_req_addr} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got req=%b dv=%b iv=%b a=%h expected 0",
                mem_req_valid, dc_rsp_valid, ic_rsp_valid, mem_req_addr);
        end
        reset = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (dc_rsp_valid || ic_rsp_valid || mem_req_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", pulses);
        end
        dc_req_valid = 1; dc_req_addr = 20'h00074;
        tick(); dc_req_valid = 0;
        wait_mem_req(n);
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 20'h00074}) begin
            errors++; $display("FAIL mid_next_req: got v=%b a=%h expected v=1 a=00074", mem_req_valid, mem_req_addr);
        end
        tick();
        mem_rsp_valid = 1; mem_rsp_data = {4{32'hCAFEF00D}};
        tick(); mem_rsp_valid = 0;
        checks++;
        if ({dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data} !== {1'b1, 1'b0, {4{32'hCAFEF00D}}}) begin
            errors++; $display("FAIL mid_next_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=cafef00d..",
                dc_rsp_valid, dc_rsp_bus_error, dc_rsp_data);
        end
        tick();
        $display("reset_mid: abort in WAIT_RSP and recovery checked");
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_dc_fill();
        test_dc_store();
        test_bus_error();
        test_round_robin();
`ifdef MEM_MISS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
